// File: rtl/multiplier_32b_signed.sv
// Sequential signed 32x32->64 Booth multiplier with start/finish handshake.
// Define MULTIPLIER_32B_SIGNED_RADIX4_EN for radix-4 Booth (16 steps instead of 32).
module multiplier_32b_signed (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product,
    output logic        busy,
    output logic        finish
);
    // state | meaning
    // IDLE  | out of reset, waiting for start
    // RUN   | one Booth step per cycle, start ignored
    // DONE  | product valid, finish high, start restarts

`ifdef MULTIPLIER_32B_SIGNED_RADIX4_EN
    localparam int AW    = 34;
    localparam int STEPS = 16;
`else
    localparam int AW    = 33;
    localparam int STEPS = 32;
`endif
    localparam logic [5:0] LAST = 6'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [32:0]     m_q;
    logic [AW-1:0]   acc_q, acc_d;
    logic [31:0]     q_q, q_d;
    logic            q1_q, q1_d;
    logic [5:0]      cnt_q;
    logic [63:0]     product_q;
    logic            busy_q, finish_q;
    logic [AW-1:0]   sum;

`ifdef MULTIPLIER_32B_SIGNED_RADIX4_EN
    logic [AW-1:0] m_ext, m2_ext;

    always_comb begin
        m_ext  = {m_q[32], m_q};
        m2_ext = {m_q, 1'b0};
        sum    = acc_q;
        case ({q_q[1:0], q1_q})
            3'b001, 3'b010: sum = acc_q + m_ext;
            3'b011:         sum = acc_q + m2_ext;
            3'b100:         sum = acc_q - m2_ext;
            3'b101, 3'b110: sum = acc_q - m_ext;
            default:        sum = acc_q;
        endcase
        acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[31:2]};
        q1_d  = q_q[1];
    end
`else
    always_comb begin
        sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_d = {sum[AW-1], sum[AW-1:1]};
        q_d   = {sum[0], q_q[31:1]};
        q1_d  = q_q[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        m_q      <= {a[31], a};
                        acc_q    <= '0;
                        q_q      <= b;
                        q1_q     <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        finish_q <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + 6'd1;
                    // The final step's result goes straight to product so it is valid with finish.
                    if (cnt_q == LAST) begin
                        product_q <= {acc_d[31:0], q_d};
                        busy_q    <= 1'b0;
                        finish_q  <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign finish  = finish_q;
endmodule
